// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, instruction width and opcodes.
// The state encoding follows the IEEE 1149.1 reference numbering (TLR = 4'hF).
package jtag_pkg;

  localparam int IR_W = 4;

  localparam logic [IR_W-1:0] EXTEST     = 4'b0000;
  localparam logic [IR_W-1:0] SAMPLE     = 4'b0001;
  localparam logic [IR_W-1:0] BYPASS     = '1;
  localparam logic [IR_W-1:0] IR_CAPTURE = 4'b0001;

  typedef enum logic [3:0] {
    EX2_DR = 4'h0,
    EX1_DR = 4'h1,
    SH_DR  = 4'h2,
    PA_DR  = 4'h3,
    SEL_IR = 4'h4,
    UPD_DR = 4'h5,
    CAP_DR = 4'h6,
    SEL_DR = 4'h7,
    EX2_IR = 4'h8,
    EX1_IR = 4'h9,
    SH_IR  = 4'hA,
    PA_IR  = 4'hB,
    RTI    = 4'hC,
    UPD_IR = 4'hD,
    CAP_IR = 4'hE,
    TLR    = 4'hF
  } tap_state_e;

  // Any opcode other than EXTEST/SAMPLE routes the scan path through bypass.
  function automatic logic is_bsr_op(input logic [IR_W-1:0] op);
    return (op == EXTEST) || (op == SAMPLE);
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP state register and tms-driven next-state logic.
// state | meaning: TLR reset, RTI idle, SEL select, CAP capture, SH shift,
//       | EX1/EX2 exit, PA pause, UPD update (each for the DR and IR columns)
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       i_tck,
  input  logic       i_rst,
  input  logic       i_tms,
  output tap_state_e o_state_q
);

  tap_state_e r_state;

  always_ff @(posedge i_tck) begin
    if (i_rst) begin
      r_state <= TLR;
    end else begin
      case (r_state)
        TLR:     r_state <= i_tms ? TLR    : RTI;
        RTI:     r_state <= i_tms ? SEL_DR : RTI;
        SEL_DR:  r_state <= i_tms ? SEL_IR : CAP_DR;
        CAP_DR:  r_state <= i_tms ? EX1_DR : SH_DR;
        SH_DR:   r_state <= i_tms ? EX1_DR : SH_DR;
        EX1_DR:  r_state <= i_tms ? UPD_DR : PA_DR;
        PA_DR:   r_state <= i_tms ? EX2_DR : PA_DR;
        EX2_DR:  r_state <= i_tms ? UPD_DR : SH_DR;
        UPD_DR:  r_state <= i_tms ? SEL_DR : RTI;
        SEL_IR:  r_state <= i_tms ? TLR    : CAP_IR;
        CAP_IR:  r_state <= i_tms ? EX1_IR : SH_IR;
        SH_IR:   r_state <= i_tms ? EX1_IR : SH_IR;
        EX1_IR:  r_state <= i_tms ? UPD_IR : PA_IR;
        PA_IR:   r_state <= i_tms ? EX2_IR : PA_IR;
        EX2_IR:  r_state <= i_tms ? UPD_IR : SH_IR;
        UPD_IR:  r_state <= i_tms ? SEL_DR : RTI;
        default: r_state <= TLR;
      endcase
    end
  end

  assign o_state_q = r_state;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: IR, bypass register, TDO mux and registered BSC strobes.
// Strobes are registered from the pre-edge state, so they lag the state by one tck.
module jtag_tap_ctrl
  import jtag_pkg::*;
(
  input  logic            tck,
  input  logic            rst,
  input  logic            tms,
  input  logic            tdi,
  output logic            tdo,
  output logic            tdo_en,
  output logic            bsr_si,
  input  logic            bsr_so,
  output logic            shift_dr,
  output logic            clock_dr,
  output logic            update_dr,
  output logic            mode,
  output logic [IR_W-1:0] ir_q,
  output logic [3:0]      tap_state
);

  tap_state_e      w_state;
  logic            w_sel_bsr;
  logic            w_sh_dr;
  logic            w_sh_ir;
  logic [IR_W-1:0] r_ir_shift;
  logic [IR_W-1:0] r_ir_q;
  logic            r_bypass;
  logic            r_tdo;
  logic            r_tdo_en;
  logic            r_shift_dr;
  logic            r_clock_dr;
  logic            r_update_dr;

  jtag_tap_fsm u_fsm (
    .i_tck     (tck),
    .i_rst     (rst),
    .i_tms     (tms),
    .o_state_q (w_state)
  );

  assign w_sel_bsr = is_bsr_op(r_ir_q);
  assign w_sh_dr   = (w_state == SH_DR);
  assign w_sh_ir   = (w_state == SH_IR);

  always_ff @(posedge tck) begin
    if (rst) begin
      r_ir_shift  <= '0;
      r_ir_q      <= BYPASS;
      r_bypass    <= 1'b0;
      r_tdo       <= 1'b0;
      r_tdo_en    <= 1'b0;
      r_shift_dr  <= 1'b0;
      r_clock_dr  <= 1'b0;
      r_update_dr <= 1'b0;
    end else begin
      if (w_state == CAP_IR)
        r_ir_shift <= IR_CAPTURE;
      else if (w_sh_ir)
        r_ir_shift <= {tdi, r_ir_shift[IR_W-1:1]};

      if (w_state == TLR)
        r_ir_q <= BYPASS;
      else if (w_state == UPD_IR)
        r_ir_q <= r_ir_shift;

      if (w_state == CAP_DR)
        r_bypass <= 1'b0;
      else if (w_sh_dr)
        r_bypass <= tdi;

      if (w_sh_ir)
        r_tdo <= r_ir_shift[0];
      else if (w_sh_dr)
        r_tdo <= w_sel_bsr ? bsr_so : r_bypass;
      else
        r_tdo <= 1'b0;

      r_tdo_en    <= w_sh_ir | w_sh_dr;
      r_shift_dr  <= w_sh_dr;
      r_clock_dr  <= w_sel_bsr & ((w_state == CAP_DR) | w_sh_dr);
      r_update_dr <= w_sel_bsr & (w_state == UPD_DR);
    end
  end

  assign bsr_si    = tdi;
  assign mode      = (r_ir_q == EXTEST);
  assign ir_q      = r_ir_q;
  assign tap_state = w_state;
  assign tdo       = r_tdo;
  assign tdo_en    = r_tdo_en;
  assign shift_dr  = r_shift_dr;
  assign clock_dr  = r_clock_dr;
  assign update_dr = r_update_dr;

endmodule
